// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a circular byte FIFO in front of the serialiser.

module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock25,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // full comes from the registered count, so a same-edge pop never frees room for a push
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock25) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock25) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx #(
  parameter int BAUD_DIV   = 217,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clock25,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tbyte,
  output logic       full,
  output logic       busy,
  output logic       tx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] baud_cnt;
  logic [15:0] baud_cnt_nx;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_nx;
  logic [7:0]  shreg;
  logic [7:0]  shreg_nx;
  logic        tx_nx;
  logic        pop;
  logic        fifo_empty;
  logic        bit_end;
  logic [7:0]  head;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock25(clock25),
    .reset  (reset),
    .push   (send),
    .wdata  (tbyte),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (fifo_empty)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign busy    = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clock25) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      shreg    <= shreg_nx;
      tx       <= tx_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    tx_nx       = tx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_nx       = 1'b1;
        baud_cnt_nx = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_nx = head;
          tx_nx    = 1'b0;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          bit_idx_nx  = '0;
          tx_nx       = shreg[0];
          shreg_nx    = {1'b0, shreg[7:1]};
          state_nx    = DATA;
        end else begin
          baud_cnt_nx = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          if (bit_idx == 3'd7) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = shreg[0];
            shreg_nx   = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_cnt_nx = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          // chain straight into the next start bit when more data is waiting
          if (!fifo_empty) begin
            pop      = 1'b1;
            shreg_nx = head;
            tx_nx    = 1'b0;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          baud_cnt_nx = baud_cnt + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end
endmodule
